// File: rtl/insn_btb_mem.sv
// insn_btb_mem
//
// Purpose:
//   Storage for the fetch stage: an instruction memory (IM) and a branch
//   target / bimodal counter memory (BT). Each array is a simple dual-port
//   RAM with one write port and one read port that may both be used in the
//   same cycle. Reads have a fixed one-cycle latency through a registered
//   output. BT writes are masked per 9-bit lane so the predictor can update
//   the target, the counter or the carry field independently.
//
// Ports:
//   clk           in   clock, all activity on the rising edge
//   reset         in   synchronous, active-high; zeroes im_q/bt_q only
//   im_wren       in   IM write enable
//   im_wraddress  in   IM write word address
//   im_data       in   IM write data (full word)
//   im_rdaddress  in   IM read word address (fetch PC[9:2])
//   im_q          out  IM read data, registered
//   bt_wren       in   BT write enable
//   bt_byteena    in   BT per-lane write enable, bit k -> bits [9k+8:9k]
//   bt_wraddress  in   BT write address
//   bt_data       in   BT write data
//                      ([35:6] target[31:2], [5:4] counter, [3:0] carry)
//   bt_rdaddress  in   BT read address
//   bt_q          out  BT read data, registered
//
// Timing contract (no handshake): a read address sampled at edge N produces
// its word on q right after edge N, held until edge N+1. A read of the
// address being written in the same edge returns the old contents; the new
// contents are visible to the next read. Reset forces q to zero at each
// edge it is high but never touches the arrays, and writes presented during
// reset are still committed.

module insn_btb_mem #(
    parameter int ADDR_W    = 8,
    parameter int IM_W      = 32,
    parameter int BT_LANE_W = 9
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     im_wren,
    input  logic [ADDR_W-1:0]        im_wraddress,
    input  logic [IM_W-1:0]          im_data,
    input  logic [ADDR_W-1:0]        im_rdaddress,
    output logic [IM_W-1:0]          im_q,

    input  logic                     bt_wren,
    input  logic [3:0]               bt_byteena,
    input  logic [ADDR_W-1:0]        bt_wraddress,
    input  logic [4*BT_LANE_W-1:0]   bt_data,
    input  logic [ADDR_W-1:0]        bt_rdaddress,
    output logic [4*BT_LANE_W-1:0]   bt_q
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BT_W  = 4 * BT_LANE_W;

    // Arrays start out all-zero; reset deliberately leaves them alone so
    // the predictor can sweep-clear counters while reset is held.
    logic [IM_W-1:0] im_mem [0:DEPTH-1] = '{default: '0};
    logic [BT_W-1:0] bt_mem [0:DEPTH-1] = '{default: '0};

    // ------------------------------------------------------------------
    // IM: full-word write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (im_wren) begin
            im_mem[im_wraddress] <= im_data;
        end
    end

    // IM read port. The array read sees the pre-edge contents because the
    // write above is non-blocking, which yields old-data read-during-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q <= '0;
        end else begin
            im_q <= im_mem[im_rdaddress];
        end
    end

    // ------------------------------------------------------------------
    // BT: lane-masked write port. Lanes with a clear enable bit keep
    // their stored value; an all-zero mask is a no-op write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bt_wren) begin
            for (int k = 0; k < 4; k++) begin
                if (bt_byteena[k]) begin
                    bt_mem[bt_wraddress][k*BT_LANE_W +: BT_LANE_W] <=
                        bt_data[k*BT_LANE_W +: BT_LANE_W];
                end
            end
        end
    end

    // BT read port, same old-data behaviour as the IM port.
    always_ff @(posedge clk) begin
        if (reset) begin
            bt_q <= '0;
        end else begin
            bt_q <= bt_mem[bt_rdaddress];
        end
    end

endmodule

// File: tb/tb_insn_btb_mem.sv
// Bench for insn_btb_mem. The driver applies one cycle of inputs at each
// falling edge and pushes the hand-computed word expected on im_q/bt_q after
// the next rising edge (plus a care flag) into the expected queues. The
// monitor pops one entry per rising edge and compares.

module tb_insn_btb_mem;

    logic        clk;
    logic        reset;
    logic        im_wren;
    logic [7:0]  im_wraddress;
    logic [31:0] im_data;
    logic [7:0]  im_rdaddress;
    logic [31:0] im_q;
    logic        bt_wren;
    logic [3:0]  bt_byteena;
    logic [7:0]  bt_wraddress;
    logic [35:0] bt_data;
    logic [7:0]  bt_rdaddress;
    logic [35:0] bt_q;

    insn_btb_mem dut (
        .clk          (clk),
        .reset        (reset),
        .im_wren      (im_wren),
        .im_wraddress (im_wraddress),
        .im_data      (im_data),
        .im_rdaddress (im_rdaddress),
        .im_q         (im_q),
        .bt_wren      (bt_wren),
        .bt_byteena   (bt_byteena),
        .bt_wraddress (bt_wraddress),
        .bt_data      (bt_data),
        .bt_rdaddress (bt_rdaddress),
        .bt_q         (bt_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [31:0] im_exp_q[$];
    logic        im_care_q[$];
    logic [35:0] bt_exp_q[$];
    logic        bt_care_q[$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    // One cycle: apply inputs now, expect (im_e, bt_e) after the next edge.
    task automatic cyc(
        input logic        rst,
        input logic        iw, input logic [7:0] iwa, input logic [31:0] id,
        input logic [7:0]  ira,
        input logic        bw, input logic [3:0] be, input logic [7:0] bwa,
        input logic [35:0] bd, input logic [7:0] bra,
        input logic        im_c, input logic [31:0] im_e,
        input logic        bt_c, input logic [35:0] bt_e);
        reset        = rst;
        im_wren      = iw;  im_wraddress = iwa; im_data = id; im_rdaddress = ira;
        bt_wren      = bw;  bt_byteena   = be;  bt_wraddress = bwa;
        bt_data      = bd;  bt_rdaddress = bra;
        im_exp_q.push_back(im_e); im_care_q.push_back(im_c);
        bt_exp_q.push_back(bt_e); bt_care_q.push_back(bt_c);
        @(negedge clk);
    endtask

    task automatic im_wr(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d, 8'h00, 1'b0, 4'h0, 8'h00, 36'h0, 8'h00,
            1'b0, 32'h0, 1'b0, 36'h0);
    endtask

    task automatic bt_wr(input logic [7:0] a, input logic [3:0] be, input logic [35:0] d);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 1'b1, be, a, d, 8'h00,
            1'b0, 32'h0, 1'b0, 36'h0);
    endtask

    task automatic rd_both(input logic [7:0] ia, input logic [31:0] ie,
                           input logic [7:0] ba, input logic [35:0] be);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, ia, 1'b0, 4'h0, 8'h00, 36'h0, ba,
            1'b1, ie, 1'b1, be);
    endtask

    task automatic rd_bt(input logic [7:0] ba, input logic [35:0] be);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 1'b0, 4'h0, 8'h00, 36'h0, ba,
            1'b0, 32'h0, 1'b1, be);
    endtask

    // monitor
    always @(posedge clk) begin
        #1;
        if (im_exp_q.size() > 0 && bt_exp_q.size() > 0) begin
            logic [31:0] ie;
            logic [35:0] be;
            logic        ic, bc;
            ie = im_exp_q.pop_front(); ic = im_care_q.pop_front();
            be = bt_exp_q.pop_front(); bc = bt_care_q.pop_front();
            if (ic) begin
                chk_cnt++;
                if (im_q === ie) pass_cnt++;
                else $display("FAIL im_q @%0t: got %h expected %h", $time, im_q, ie);
            end
            if (bc) begin
                chk_cnt++;
                if (bt_q === be) pass_cnt++;
                else $display("FAIL bt_q @%0t: got %h expected %h", $time, bt_q, be);
            end
        end
    end

    // stimulus
    initial begin
        reset = 1'b1;
        im_wren = 1'b0; im_wraddress = '0; im_data = '0; im_rdaddress = '0;
        bt_wren = 1'b0; bt_byteena = '0; bt_wraddress = '0; bt_data = '0;
        bt_rdaddress = '0;

        // reset holds q at zero
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 8'h33, 1'b0, 4'h0, 8'h00, 36'h0, 8'h33,
            1'b1, 32'h0, 1'b1, 36'h0);
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 8'h33, 1'b0, 4'h0, 8'h00, 36'h0, 8'h33,
            1'b1, 32'h0, 1'b1, 36'h0);

        // never-written address reads zero
        rd_both(8'h33, 32'h0, 8'h33, 36'h0);

        // write + same-cycle read returns old data, next read the new word
        cyc(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 8'h05, 1'b1, 4'hF, 8'h10,
            36'hABCDE1234, 8'h10, 1'b1, 32'h0, 1'b1, 36'h0);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 8'h05, 1'b1, 4'h1, 8'h10,
            36'h0000001FF, 8'h10, 1'b1, 32'hDEADBEEF, 1'b1, 36'hABCDE1234);
        rd_bt(8'h10, 36'hABCDE13FF);

        // empty mask leaves the word untouched
        bt_wr(8'h10, 4'h0, 36'hFFFFFFFFF);
        rd_bt(8'h10, 36'hABCDE13FF);

        // single middle lane
        bt_wr(8'h11, 4'h4, 36'hFFFFFFFFF);
        rd_bt(8'h11, 36'h007FC0000);

        // IM read-during-write at 0x20
        im_wr(8'h20, 32'h22222222);
        cyc(1'b0, 1'b1, 8'h20, 32'h11111111, 8'h20, 1'b0, 4'h0, 8'h00, 36'h0, 8'h00,
            1'b1, 32'h22222222, 1'b0, 36'h0);
        rd_both(8'h20, 32'h11111111, 8'h10, 36'hABCDE13FF);

        // contents for back-to-back and reset-sweep tests
        im_wr(8'h00, 32'hA0A0A0A0);
        im_wr(8'hFF, 32'hF0F0F0F0);
        im_wr(8'h01, 32'h01010101);
        bt_wr(8'h00, 4'hF, 36'h123456789);
        bt_wr(8'hFF, 4'hF, 36'hFEDCBA987);
        bt_wr(8'h01, 4'hF, 36'h0F0F0F0F0);
        bt_wr(8'h02, 4'hF, 36'hFFFFFFFFF);
        bt_wr(8'h03, 4'hF, 36'h555555555);

        // back-to-back reads, no bubbles
        rd_both(8'h00, 32'hA0A0A0A0, 8'h00, 36'h123456789);
        rd_both(8'hFF, 32'hF0F0F0F0, 8'hFF, 36'hFEDCBA987);
        rd_both(8'h01, 32'h01010101, 8'h01, 36'h0F0F0F0F0);

        // reset sweep: lane 0 cleared at 0..2, q zero, IM write still lands
        cyc(1'b1, 1'b1, 8'h40, 32'hCAFEF00D, 8'h40, 1'b1, 4'h1, 8'h00, 36'h0, 8'h03,
            1'b1, 32'h0, 1'b1, 36'h0);
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 8'h40, 1'b1, 4'h1, 8'h01, 36'h0, 8'h03,
            1'b1, 32'h0, 1'b1, 36'h0);
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 8'h40, 1'b1, 4'h1, 8'h02, 36'h0, 8'h03,
            1'b1, 32'h0, 1'b1, 36'h0);
        rd_both(8'h40, 32'hCAFEF00D, 8'h03, 36'h555555555);
        rd_both(8'h05, 32'hDEADBEEF, 8'h00, 36'h123456600);
        rd_bt(8'h01, 36'h0F0F0F000);
        rd_bt(8'h02, 36'hFFFFFFE00);

        // mid-stream reset discards one result only
        rd_both(8'hFF, 32'hF0F0F0F0, 8'hFF, 36'hFEDCBA987);
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 8'h01, 1'b0, 4'h0, 8'h00, 36'h0, 8'h01,
            1'b1, 32'h0, 1'b1, 36'h0);
        rd_both(8'h01, 32'h01010101, 8'h01, 36'h0F0F0F000);
        rd_both(8'h20, 32'h11111111, 8'h11, 36'h007FC0000);

        // drain, bounded
        for (int i = 0; i < 10 && im_exp_q.size() > 0; i++) @(negedge clk);
        if (im_exp_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", im_exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/insn_btb_mem.md
INSN_BTB_MEM -- requirements
Module: insn_btb_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: address width of both arrays (depth 2^ADDR_W = 256 words).
REQ-002 SHALL have parameter IM_W, default 32: instruction word width.
REQ-003 SHALL have parameter BT_LANE_W, default 9: BTB byte-lane width; the BTB word is 4 lanes = 36 bits.
REQ-004 clk  input  1  clock; all activity on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 im_wren  input  1  instruction-memory write enable.
REQ-007 im_wraddress  input  8  instruction-memory write word address.
REQ-008 im_data  input  32  instruction-memory write data.
REQ-009 im_rdaddress  input  8  instruction-memory read word address (fetch PC[9:2]).
REQ-010 im_q  output  32  instruction-memory read data.
REQ-011 bt_wren  input  1  BTB/bimodal memory write enable.
REQ-012 bt_byteena  input  4  per-lane write enable; bit k covers data bits [9k+8:9k].
REQ-013 bt_wraddress  input  8  BTB write address.
REQ-014 bt_data  input  36  BTB write data ([35:6] target[31:2], [5:4] bimodal counter, [3:0] carry).
REQ-015 bt_rdaddress  input  8  BTB read address.
REQ-016 bt_q  output  36  BTB read data.

Function
REQ-017 Two independent simple-dual-port RAMs SHALL be provided: IM (256 x 32) and BT (256 x 36); one read port and one write port each, all usable in the same cycle.
REQ-018 Read latency SHALL be 1 cycle: address sampled at edge N, data valid on q after edge N and held until edge N+1.
REQ-019 q outputs SHALL be registered and change only on a rising clk edge.
REQ-020 IM write: when im_wren=1 at an edge, mem[im_wraddress] <= im_data (full word).
REQ-021 BT write: when bt_wren=1 at an edge, only lanes with bt_byteena[k]=1 SHALL be updated; other lanes keep old value.
REQ-022 bt_byteena=0000 with bt_wren=1 SHALL leave the word unchanged.
REQ-023 Read-during-write to the same address in the same cycle SHALL return OLD data; new data readable from the following read.
REQ-024 Writes to different addresses SHALL not disturb other words; addresses wrap naturally within 8 bits (no out-of-range case).
REQ-025 All array contents SHALL power up / initialize to zero (simulation initial value).

Reset
REQ-026 While reset=1 at an edge, im_q and bt_q SHALL be loaded with 0 instead of read data.
REQ-027 Reset SHALL NOT clear array contents; writes asserted during reset SHALL still be performed (used by the predictor to sweep-clear bimodal counters).
REQ-028 First edge with reset=0 SHALL resume normal 1-cycle reads of the sampled address.
REQ-029 Reset asserted mid-stream SHALL discard the pending read result (q=0) with no effect on later reads.

Verification
REQ-030 IM write 0xDEADBEEF @0x05, then read 0x05 -> im_q=0xDEADBEEF exactly one cycle after read address sampled.
REQ-031 BT full write 36'hABCDE1234 @0x10 with byteena=1111, then byteena=0001 write 36'h0000001FF @0x10 -> read gives 36'hABCDE13FF.
REQ-032 Same-cycle write 0x11111111 and read of IM @0x20 holding 0x22222222 -> im_q=0x22222222; next read -> 0x11111111.
REQ-033 reset=1 for 3 cycles while writing bt_data=0 byteena=0001 to addresses 0,1,2 and reading addr 3 -> bt_q=0 during reset; afterwards lanes [8:0] of 0..2 read 0, upper lanes unchanged.
REQ-034 Back-to-back reads of addresses 0x00,0xFF,0x01 with distinct contents -> q shows each word in order, one per cycle, no bubbles.
REQ-035 Read of never-written address after power-up -> im_q=0, bt_q=0.
